count_checker: RTL
==================

COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 Parameter LOCK_N, default 4: consecutive correct increments needed to declare lock, range 1..15.
REQ-002 Parameter WRAP_W, default 8: width of wrap counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  sample valid; c is evaluated only on edges where en=1.
REQ-006 c  input  4  count value from the upstream 4-bit counter.
REQ-007 clr  input  1  synchronous clear of state, counters and sticky flag.
REQ-008 state  output  2  FSM state: IDLE=00, SYNC=01, LOCK=10, FAIL=11.
REQ-009 locked  output  1  high iff state==LOCK.
REQ-010 err  output  1  one-cycle pulse per detected sequence error while locked.
REQ-011 err_sticky  output  1  set on any err, cleared only by rst/clr.
REQ-012 err_cnt  output  8  error count, saturating at 255.
REQ-013 wrap_cnt  output  WRAP_W  number of 15->0 wraps seen in LOCK, modulo 2^WRAP_W.

Function
REQ-014 All outputs shall be registered; the effect of a sample taken at edge k shall be visible after edge k (latency 1 edge).
REQ-015 "Correct" shall mean c == (prev+1) mod 16; prev is the last sampled c, updated on every edge with en=1 (except when clr=1).
REQ-016 Equal value (c==prev) or any skip shall count as incorrect.
REQ-017 IDLE: on first en=1, capture prev=c, clear good count, go to SYNC; no check performed.
REQ-018 SYNC/FAIL: correct -> good count +1; when good count reaches LOCK_N go to LOCK; incorrect -> good count=0, stay, no err.
REQ-019 LOCK: correct -> stay; incorrect -> err=1 for one cycle, err_cnt+1 (saturating), err_sticky=1, good count=0, go to FAIL.
REQ-020 wrap_cnt shall increment only in LOCK when prev==15 and c==0.
REQ-021 en=0 shall hold all state and counters; err shall be 0 on any edge without a detected error.
REQ-022 clr=1 shall return to IDLE and zero err_cnt, wrap_cnt, err_sticky, good count, err; clr overrides a simultaneous en sample, which is discarded.
REQ-023 err_cnt at 255 shall stay 255 on further errors while err still pulses.

Reset
REQ-024 rst=1 shall immediately, without a clock edge, force state=IDLE and all outputs and internal registers to 0.
REQ-025 Reset asserted mid-operation (any state) shall abandon the sequence; the first en sample after release shall be treated as an IDLE capture.

Structure
REQ-026 State encodings, default LOCK_N and error counter width shall live in shared package count_check_pkg.
REQ-027 The saturating error counter shall be a sub-module sat_cnt (width parameter, inc, clr, value).

Verification
REQ-028 rst pulse, en=1, c=0,1,2,3,4 -> state 01 after c=0; locked=1 after the edge sampling c=4; err never 1.
REQ-029 Locked, c continues 5..15,0 -> wrap_cnt=1 after edge sampling 0; locked stays 1.
REQ-030 Locked at c=5, inject c=7 -> err=1 one cycle, err_cnt=1, err_sticky=1, state=11; then 8,9,10,11 -> locked=1, err_sticky still 1.
REQ-031 Alternate correct/skip in LOCK/FAIL for 300 errors -> err_cnt=255, err pulses on each error.
REQ-032 Assert rst between edges while locked -> all outputs 0 before next edge; after release, c=9,10,11,12,13 -> locked after sampling 13.
REQ-033 clr=1 and en=1 same edge while locked with err_cnt=3 -> state=00, err_cnt=0, wrap_cnt=0, err_sticky=0.

Source files
------------

// File: rtl/count_check_pkg.sv
// Shared definitions for the count checker.
//   - FSM state encodings (also the encoding seen on the state output)
//   - default lock threshold and error counter width
//   - is_next(): true when n is the modulo-16 successor of p
package count_check_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_SYNC = 2'b01;
    localparam state_t ST_LOCK = 2'b10;
    localparam state_t ST_FAIL = 2'b11;

    localparam int LOCK_N_DEF = 4;
    localparam int ERR_CNT_W  = 8;

    // The upstream counter is 4 bits wide, so 15 -> 0 is a valid step.
    function automatic logic is_next(input logic [3:0] p, input logic [3:0] n);
        return n == (p + 4'd1);
    endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk   - clock
//   rst   - asynchronous active-high reset
//   inc   - add one this edge unless already at the maximum value
//   clr   - synchronous clear to zero, overrides inc
//   value - current count
module sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && (value != {W{1'b1}})) begin
            value <= value + W'(1);
        end
    end

endmodule

// File: rtl/count_checker.sv
// Checks that a sampled 4-bit count advances by exactly one per valid
// sample, declares lock after LOCK_N consecutive good steps and flags
// sequence errors seen while locked.
// Ports:
//   clk        - clock, all updates on the rising edge
//   rst        - asynchronous active-high reset
//   en         - sample valid; c is evaluated only when en=1
//   c          - count value from the upstream counter
//   clr        - synchronous clear of state, counters and sticky flag
//   state      - FSM state (see table below)
//   locked     - high iff state is LOCK
//   err        - one-cycle pulse per error detected while locked
//   err_sticky - set on any err, cleared by rst/clr
//   err_cnt    - saturating error count
//   wrap_cnt   - 15->0 wraps seen while locked, modulo 2^WRAP_W
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for the first sample; it is captured, not checked
// SYNC  | counting consecutive good steps towards lock
// LOCK  | locked; a bad step raises err and drops to FAIL
// FAIL  | lost lock; counting good steps to re-lock, no further errors
module count_checker
    import count_check_pkg::*;
#(
    parameter int LOCK_N = LOCK_N_DEF,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [3:0]        c,
    input  logic              clr,
    output logic [1:0]        state,
    output logic              locked,
    output logic              err,
    output logic              err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [WRAP_W-1:0] wrap_cnt
);

    localparam logic [4:0] LOCK_N_V = 5'(LOCK_N);

    state_t            state_nxt;
    logic [3:0]        prev;
    logic [3:0]        prev_nxt;
    logic [3:0]        good;
    logic [3:0]        good_nxt;
    logic [4:0]        good_inc;
    logic [WRAP_W-1:0] wrap_nxt;
    logic              step_ok;
    logic              err_hit;

    assign step_ok  = is_next(prev, c);
    assign good_inc = {1'b0, good} + 5'd1;

    always_comb begin
        state_nxt = state;
        prev_nxt  = prev;
        good_nxt  = good;
        wrap_nxt  = wrap_cnt;
        err_hit   = 1'b0;

        if (clr) begin
            // Any sample arriving with clr is discarded.
            state_nxt = ST_IDLE;
            prev_nxt  = '0;
            good_nxt  = '0;
            wrap_nxt  = '0;
        end else if (en) begin
            prev_nxt = c;
            case (state)
                ST_IDLE: begin
                    good_nxt  = '0;
                    state_nxt = ST_SYNC;
                end
                ST_SYNC, ST_FAIL: begin
                    if (step_ok) begin
                        good_nxt = good_inc[3:0];
                        if (good_inc == LOCK_N_V) begin
                            state_nxt = ST_LOCK;
                        end
                    end else begin
                        good_nxt = '0;
                    end
                end
                default: begin
                    if (step_ok) begin
                        if (prev == 4'd15) begin
                            wrap_nxt = wrap_cnt + WRAP_W'(1);
                        end
                    end else begin
                        err_hit   = 1'b1;
                        good_nxt  = '0;
                        state_nxt = ST_FAIL;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            prev       <= '0;
            good       <= '0;
            wrap_cnt   <= '0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            locked     <= 1'b0;
        end else begin
            state    <= state_nxt;
            prev     <= prev_nxt;
            good     <= good_nxt;
            wrap_cnt <= wrap_nxt;
            err      <= err_hit;
            locked   <= (state_nxt == ST_LOCK);
            if (clr) begin
                err_sticky <= 1'b0;
            end else if (err_hit) begin
                err_sticky <= 1'b1;
            end
        end
    end

    sat_cnt #(
        .W(ERR_CNT_W)
    ) u_err_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (err_hit),
        .clr  (clr),
        .value(err_cnt)
    );

endmodule
